// File: rtl/sdft_bin_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sdft_bin_sequencer_pkg
// Shared definitions for the sliding-DFT bin scheduler and its neighbours
// (MAC, bin RAM): sequencer state encoding and default geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package sdft_bin_sequencer_pkg;

    // Sequencer phases: IDLE waits for a sample, RUN issues one bin address
    // per cycle, DRAIN waits for the MAC pipeline to finish write-back.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    localparam int DEF_ADDR_WIDTH  = 7;  // N = 128 bins
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_MAC_LATENCY = 2;

endpackage

// File: rtl/sdft_pipe_delay.sv
// -----------------------------------------------------------------------------
// sdft_pipe_delay
// Shift register carrying {valid, index} through `depth` stages. Stage 0 is
// the cycle after issue (ROM/RAM data registered -> MAC inputs valid); the
// last stage is when the MAC result is ready for write-back.
// Ports:
//   clk, reset    clock, synchronous active-high clear of all stages
//   in_valid      an address is being issued this cycle
//   in_idx        the issued bin index
//   head_valid    stage 0 valid (drives mac_valid)
//   tail_valid    last stage valid (drives bin_wr_en)
//   tail_idx      last stage index (drives bin_wr_addr)
//   inflight      any stage except the last is still valid
// -----------------------------------------------------------------------------
module sdft_pipe_delay #(
    parameter int depth     = 3,
    parameter int idx_width = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [idx_width-1:0] in_idx,
    output logic                 head_valid,
    output logic                 tail_valid,
    output logic [idx_width-1:0] tail_idx,
    output logic                 inflight
);

    logic [depth-1:0]                vld;
    logic [depth-1:0][idx_width-1:0] idx;

    // Invalid slots carry index 0 so bin_wr_addr reads 0 when nothing is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            idx <= '0;
        end else begin
            vld <= {vld[depth-2:0], in_valid};
            idx <= {idx[depth-2:0], (in_valid ? in_idx : {idx_width{1'b0}})};
        end
    end

    assign head_valid = vld[0];
    assign tail_valid = vld[depth-1];
    assign tail_idx   = idx[depth-1];
    assign inflight   = |vld[depth-2:0];

endmodule

// File: rtl/sdft_bin_sequencer.sv
// -----------------------------------------------------------------------------
// sdft_bin_sequencer
// Per-sample scheduler for the sliding-DFT core. On an accepted sample it
// latches delta = sample_in - oldest_in, then walks bins 0..N-1 one per cycle,
// driving twiddle-ROM / bin-RAM read addresses, flagging the MAC when the
// registered ROM/RAM data is valid and issuing bin-RAM write-back after the
// MAC pipeline.
//
// Handshake: sample_valid is a one-cycle strobe with no ready. It is accepted
// only when busy is low (this includes the done cycle); a strobe while busy is
// dropped and sets the sticky overrun flag.
//
// Optional build macro SDFT_OVERRUN_CNT_EN adds overrun_cnt, a saturating
// 16-bit count of dropped samples.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   sample_valid   new-sample strobe
//   sample_in      new sample (signed)
//   oldest_in      sample leaving the window (signed)
//   busy           sequence in progress
//   done           one-cycle pulse after the last write-back
//   overrun        sticky: sample dropped while busy
//   delta          latched sample_in - oldest_in (data_width+1 bits)
//   twid_addr      twiddle ROM address
//   bin_rd_addr    bin RAM read address (same as twid_addr)
//   mac_valid      MAC inputs valid
//   bin_wr_en      bin RAM write enable
//   bin_wr_addr    bin RAM write address
//   overrun_cnt    dropped-sample count (SDFT_OVERRUN_CNT_EN only)
//   dbg_state      current sequencer state (seq_state_t encoding)
// -----------------------------------------------------------------------------
module sdft_bin_sequencer
    import sdft_bin_sequencer_pkg::*;
#(
    parameter int addr_width  = DEF_ADDR_WIDTH,
    parameter int data_width  = DEF_DATA_WIDTH,
    parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [data_width-1:0] sample_in,
    input  logic [data_width-1:0] oldest_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [data_width:0]   delta,
    output logic [addr_width-1:0] twid_addr,
    output logic [addr_width-1:0] bin_rd_addr,
    output logic                  mac_valid,
    output logic                  bin_wr_en,
    output logic [addr_width-1:0] bin_wr_addr,
`ifdef SDFT_OVERRUN_CNT_EN
    output logic [15:0]           overrun_cnt,
`endif
    output logic [1:0]            dbg_state
);

    seq_state_t state;
    logic       pipe_inflight;
    logic       issue;

    // An address is issued on every RUN cycle; twid_addr is the index.
    assign issue       = (state == ST_RUN);
    assign bin_rd_addr = twid_addr;
    assign dbg_state   = state;

    sdft_pipe_delay #(
        .depth     (MAC_LATENCY + 1),
        .idx_width (addr_width)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (issue),
        .in_idx     (twid_addr),
        .head_valid (mac_valid),
        .tail_valid (bin_wr_en),
        .tail_idx   (bin_wr_addr),
        .inflight   (pipe_inflight)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            twid_addr <= '0;
            delta     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sample_valid && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        // Sign-extend both operands one bit: the difference always fits.
                        delta     <= {sample_in[data_width-1], sample_in}
                                   - {oldest_in[data_width-1], oldest_in};
                        twid_addr <= '0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (twid_addr == '1) begin
                        state <= ST_DRAIN;
                    end else begin
                        twid_addr <= twid_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave when only the final write-back remains: it happens this
                    // cycle, so busy drops and done pulses right after it.
                    if (!pipe_inflight) begin
                        state     <= ST_IDLE;
                        twid_addr <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SDFT_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (sample_valid && busy && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdft_bin_sequencer.sv
module tb_sdft_bin_sequencer;

    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int N   = 1 << AW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [DW-1:0] oldest_in = '0;
    logic          busy, done, overrun, mac_valid, bin_wr_en;
    logic [DW:0]   delta;
    logic [AW-1:0] twid_addr, bin_rd_addr, bin_wr_addr;
    logic [1:0]    dbg_state;
`ifdef SDFT_OVERRUN_CNT_EN
    logic [15:0]   overrun_cnt;
`endif

    always #5 clk = ~clk;

    sdft_bin_sequencer #(
        .addr_width  (AW),
        .data_width  (DW),
        .MAC_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .oldest_in    (oldest_in),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .delta        (delta),
        .twid_addr    (twid_addr),
        .bin_rd_addr  (bin_rd_addr),
        .mac_valid    (mac_valid),
        .bin_wr_en    (bin_wr_en),
        .bin_wr_addr  (bin_wr_addr),
`ifdef SDFT_OVERRUN_CNT_EN
        .overrun_cnt  (overrun_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, $signed(obs), $signed(exp));
        end
    endtask

    // ---------------- reference model ----------------
    // A sequence accepted in cycle a is described purely by offsets from a.
    int            cyc = 0;
    bit            checks_en = 0;
    bit            active = 0;
    int            seq_a = 0;
    int            m_delta = 0;
    bit            m_overrun = 0;
    int            m_cnt = 0;
    logic [AW-1:0] exp_q[$];

    function automatic bit m_busy(input int t);
        int rel;
        rel = t - seq_a;
        return active && (rel >= 1) && (rel <= N + 1 + LAT);
    endfunction

    task automatic check_cycle();
        int rel;
        bit exp_mac, exp_wr;
        logic [AW-1:0] exp_addr;
        rel     = cyc - seq_a;
        exp_mac = active && (rel - 2 >= 0) && (rel - 2 <= N - 1);
        exp_wr  = active && (rel - 2 - LAT >= 0) && (rel - 2 - LAT <= N - 1);
        check_eq("busy", busy, m_busy(cyc));
        check_eq("done", done, active && (rel == N + 2 + LAT));
        check_eq("mac_valid", mac_valid, exp_mac);
        check_eq("bin_wr_en", bin_wr_en, exp_wr);
        if (bin_wr_en === 1'b1) begin
            if (exp_q.size() > 0) begin
                exp_addr = exp_q.pop_front();
                check_eq("bin_wr_addr", bin_wr_addr, exp_addr);
            end else begin
                check_eq("wr_spurious", bin_wr_en, 0);
            end
        end
        if (active && rel >= 1 && rel <= N) begin
            check_eq("twid_addr", twid_addr, rel - 1);
            check_eq("bin_rd_addr", bin_rd_addr, rel - 1);
        end else if (!m_busy(cyc)) begin
            check_eq("twid_addr_idle", twid_addr, 0);
        end
        check_eq("delta", 32'($signed(delta)), m_delta);
        check_eq("overrun", overrun, m_overrun);
`ifdef SDFT_OVERRUN_CNT_EN
        check_eq("overrun_cnt", overrun_cnt, m_cnt);
`endif
    endtask

    // ---------------- driver ----------------
    // One cycle: check what the DUT shows now, then drive inputs sampled at
    // the next posedge and advance the model.
    task automatic step(input bit sv, input int s, input int o, input bit rst);
        @(negedge clk);
        if (checks_en) check_cycle();
        sample_valid = sv;
        sample_in    = s[DW-1:0];
        oldest_in    = o[DW-1:0];
        reset        = rst;
        if (rst) begin
            active    = 0;
            m_overrun = 0;
            m_cnt     = 0;
            m_delta   = 0;
            exp_q.delete();
            checks_en = 1;
        end else if (sv) begin
            if (m_busy(cyc)) begin
                m_overrun = 1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                active  = 1;
                seq_a   = cyc;
                m_delta = s - o;
                for (int k = 0; k < N; k++) exp_q.push_back(AW'(k));
            end
        end
        cyc++;
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic idle_until(input int t);
        while (cyc < t) step(0, rnd_s(), rnd_s(), 0);
    endtask

    // ---------------- stimulus ----------------
    int a;

    initial begin
        repeat (3) step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);

        // basic sequence with a dropped sample in the middle
        a = cyc;
        step(1, 5, -3, 0);
        idle_until(a + 50);
        step(1, rnd_s(), rnd_s(), 0);

        // back-to-back: new sample in the done cycle
        idle_until(a + N + 2 + LAT);
        a = cyc;
        step(1, -128, 127, 0);

        // reset in the middle of a sequence, then clean restart
        idle_until(a + N + 2 + LAT + 3);
        a = cyc;
        step(1, 127, -128, 0);
        idle_until(a + 60);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);

        // randomized sequences with occasional stray strobes
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) step(0, rnd_s(), rnd_s(), 0);
            step(1, rnd_s(), rnd_s(), 0);
            for (int i = 0; i < N + 2 + LAT; i++)
                step($urandom_range(0, 39) == 0, rnd_s(), rnd_s(), 0);
        end

        repeat (N + LAT + 8) step(0, 0, 0, 0);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
